// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command decoder.
package uart_cmd_pkg;

    localparam int unsigned GAP_CNT_W = 16;

    localparam logic [3:0] OP_CH_SEL  = 4'h1;
    localparam logic [3:0] OP_LAYOUT  = 4'h2;
    localparam logic [3:0] OP_ZOOM    = 4'h3;
    localparam logic [3:0] OP_BRIGHT  = 4'h4;
    localparam logic [3:0] OP_RESTORE = 4'hF;

    localparam logic [3:0] BRIGHT_DEC  = 4'h0;
    localparam logic [3:0] BRIGHT_INC  = 4'h1;
    localparam logic [3:0] RESTORE_KEY = 4'hA;

    localparam logic [3:0] ACK_PREFIX = 4'hA;
    localparam logic [3:0] NAK_PREFIX = 4'hE;

    typedef enum logic [1:0] {
        ACK_IDLE = 2'd0,
        ACK_SEND = 2'd1,
        ACK_GAP  = 2'd2
    } ack_state_t;

    typedef struct packed {
        logic [1:0] ch_sel;
        logic [1:0] layout_mode;
        logic [2:0] zoom_level;
        logic [3:0] brightness;
    } cfg_t;

    // Feedback byte: accept/reject prefix in the high nibble, echoed opcode below.
    function automatic logic [7:0] ack_byte(input logic valid, input logic [3:0] opcode);
        return {(valid ? ACK_PREFIX : NAK_PREFIX), opcode};
    endfunction

endpackage

// File: rtl/ack_gap_timer.sv
// Down-counter that holds off the next ack strobe for CYCLES clocks after a load.
module ack_gap_timer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CYCLES = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done_c
);

    // A zero gap would never reach the terminal count, so it is treated as one cycle.
    localparam logic [GAP_CNT_W-1:0] LOAD_VAL =
        (CYCLES == 0) ? GAP_CNT_W'(1) : GAP_CNT_W'(CYCLES);

    logic [GAP_CNT_W-1:0] cnt_q;

    // Load on request, otherwise count down to zero and park there.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - GAP_CNT_W'(1);
        end
    end

    assign done_c = (cnt_q == GAP_CNT_W'(1));

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes UART command nibbles into video config registers and returns an ack byte.
// Optional macro UART_CMD_ACK_EN enables the ack byte/strobe path; without it the
// ack outputs are tied low.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned ACK_GAP_CYCLES = 5000,
    parameter int unsigned BRIGHT_DEFAULT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ctrl_command,
    input  logic [3:0] value_command,
    input  logic       data_ready,
    output logic [1:0] ch_sel,
    output logic [1:0] layout_mode,
    output logic [2:0] zoom_level,
    output logic [3:0] brightness,
    output logic       cfg_update,
    output logic [7:0] ack_data,
    output logic       ack_flag,
    output logic       ack_overrun
);

    localparam cfg_t CFG_RST = '{
        ch_sel:      2'd0,
        layout_mode: 2'd0,
        zoom_level:  3'd0,
        brightness:  4'(BRIGHT_DEFAULT)
    };

    cfg_t cfg_q;
    cfg_t cfg_nxt;
    logic cmd_valid;

    // Decode the presented command into a candidate config and a validity flag.
    always_comb begin
        cfg_nxt   = cfg_q;
        cmd_valid = 1'b0;
        case (ctrl_command)
            OP_CH_SEL: begin
                if (value_command <= 4'd3) begin
                    cfg_nxt.ch_sel = value_command[1:0];
                    cmd_valid      = 1'b1;
                end
            end
            OP_LAYOUT: begin
                if (value_command <= 4'd3) begin
                    cfg_nxt.layout_mode = value_command[1:0];
                    cmd_valid           = 1'b1;
                end
            end
            OP_ZOOM: begin
                if (value_command <= 4'd7) begin
                    cfg_nxt.zoom_level = value_command[2:0];
                    cmd_valid          = 1'b1;
                end
            end
            OP_BRIGHT: begin
                if (value_command == BRIGHT_DEC) begin
                    cmd_valid = 1'b1;
                    if (cfg_q.brightness != 4'd0) begin
                        cfg_nxt.brightness = cfg_q.brightness - 4'd1;
                    end
                end else if (value_command == BRIGHT_INC) begin
                    cmd_valid = 1'b1;
                    if (cfg_q.brightness != 4'd15) begin
                        cfg_nxt.brightness = cfg_q.brightness + 4'd1;
                    end
                end
            end
            OP_RESTORE: begin
                if (value_command == RESTORE_KEY) begin
                    cfg_nxt   = CFG_RST;
                    cmd_valid = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Config registers update one edge after the strobe; pulse only on a real change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_q      <= CFG_RST;
            cfg_update <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            if (data_ready && cmd_valid) begin
                cfg_q      <= cfg_nxt;
                cfg_update <= (cfg_nxt != cfg_q);
            end
        end
    end

    assign ch_sel      = cfg_q.ch_sel;
    assign layout_mode = cfg_q.layout_mode;
    assign zoom_level  = cfg_q.zoom_level;
    assign brightness  = cfg_q.brightness;

`ifdef UART_CMD_ACK_EN

    ack_state_t state_q;
    ack_state_t state_nxt;
    logic       pend_valid_q;
    logic [7:0] pend_data_q;
    logic       consume_c;
    logic       load_c;
    logic       gap_done_c;
    logic       flag_nxt;
    logic [7:0] data_nxt;

    ack_gap_timer #(
        .CYCLES (ACK_GAP_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .done_c (gap_done_c)
    );

    // Ack state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ACK_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Ack sequencing: take the pending byte, strobe once, then hold off for the gap.
    always_comb begin
        state_nxt = state_q;
        consume_c = 1'b0;
        load_c    = 1'b0;
        flag_nxt  = 1'b0;
        data_nxt  = ack_data;
        case (state_q)
            ACK_IDLE: begin
                if (pend_valid_q) begin
                    state_nxt = ACK_SEND;
                    consume_c = 1'b1;
                    flag_nxt  = 1'b1;
                    data_nxt  = pend_data_q;
                end
            end
            ACK_SEND: begin
                state_nxt = ACK_GAP;
                load_c    = 1'b1;
            end
            ACK_GAP: begin
                if (gap_done_c) begin
                    state_nxt = ACK_IDLE;
                end
            end
            default: state_nxt = ACK_IDLE;
        endcase
    end

    // One-deep pending buffer; a new byte replaces an unsent one and flags the loss.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
            ack_data     <= 8'h00;
            ack_flag     <= 1'b0;
            ack_overrun  <= 1'b0;
        end else begin
            ack_data <= data_nxt;
            ack_flag <= flag_nxt;
            if (data_ready) begin
                pend_valid_q <= 1'b1;
                pend_data_q  <= ack_byte(cmd_valid, ctrl_command);
                if (pend_valid_q && !consume_c) begin
                    ack_overrun <= 1'b1;
                end
            end else if (consume_c) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

`else

    assign ack_data    = 8'h00;
    assign ack_flag    = 1'b0;
    assign ack_overrun = 1'b0;

`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder (ack path per UART_CMD_ACK_EN).
module tb_uart_cmd_decoder;

    localparam int unsigned G  = 8;
    localparam int unsigned BD = 8;
`ifdef UART_CMD_ACK_EN
    localparam int ACK_N = 1;
`else
    localparam int ACK_N = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ctrl_command;
    logic [3:0] value_command;
    logic       data_ready;
    logic [1:0] ch_sel;
    logic [1:0] layout_mode;
    logic [2:0] zoom_level;
    logic [3:0] brightness;
    logic       cfg_update;
    logic [7:0] ack_data;
    logic       ack_flag;
    logic       ack_overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [7:0] ackq[$];
    int         ackt[$];

    uart_cmd_decoder #(
        .ACK_GAP_CYCLES (G),
        .BRIGHT_DEFAULT (BD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_command  (ctrl_command),
        .value_command (value_command),
        .data_ready    (data_ready),
        .ch_sel        (ch_sel),
        .layout_mode   (layout_mode),
        .zoom_level    (zoom_level),
        .brightness    (brightness),
        .cfg_update    (cfg_update),
        .ack_data      (ack_data),
        .ack_flag      (ack_flag),
        .ack_overrun   (ack_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every ack strobe with its cycle stamp.
    always @(negedge clk) begin
        if (ack_flag === 1'b1) begin
            ackq.push_back(ack_data);
            ackt.push_back(cyc);
        end
    end

    // Called at a negedge; presents one command for exactly one edge, then junk with data_ready low.
    task automatic send_cmd(input logic [3:0] op, input logic [3:0] val);
        ctrl_command  = op;
        value_command = val;
        data_ready    = 1'b1;
        @(negedge clk);
        data_ready    = 1'b0;
        ctrl_command  = 4'h1;
        value_command = 4'h3;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; data_ready = 1'b0; ctrl_command = 4'h1; value_command = 4'h3;
        drain(3);
        n_tests++; if (ch_sel !== 2'd0) begin n_fail++; $display("FAIL reset_ch_sel: got %0d want 0", ch_sel); end
        n_tests++; if (layout_mode !== 2'd0) begin n_fail++; $display("FAIL reset_layout: got %0d want 0", layout_mode); end
        n_tests++; if (zoom_level !== 3'd0) begin n_fail++; $display("FAIL reset_zoom: got %0d want 0", zoom_level); end
        n_tests++; if (brightness !== 4'(BD)) begin n_fail++; $display("FAIL reset_bright: got %0d want %0d", brightness, BD); end
        n_tests++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_update: got %b want 0", cfg_update); end
        n_tests++; if (ack_data !== 8'h00) begin n_fail++; $display("FAIL reset_ack_data: got %h want 00", ack_data); end
        n_tests++; if (ack_flag !== 1'b0) begin n_fail++; $display("FAIL reset_ack_flag: got %b want 0", ack_flag); end
        n_tests++; if (ack_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", ack_overrun); end
        rst = 1'b1;
    endtask

    task automatic test_ch_sel();
        ackq.delete(); ackt.delete();
        send_cmd(4'h1, 4'h2);
        n_tests++; if (ch_sel !== 2'd2) begin n_fail++; $display("FAIL ch_sel_update: got %0d want 2", ch_sel); end
        n_tests++; if (cfg_update !== 1'b1) begin n_fail++; $display("FAIL ch_cfg_pulse: got %b want 1", cfg_update); end
        drain(1);
        n_tests++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL ch_cfg_pulse_end: got %b want 0", cfg_update); end
        drain(G + 6);
        n_tests++; if (ch_sel !== 2'd2) begin n_fail++; $display("FAIL ch_ignore_idle_inputs: got %0d want 2", ch_sel); end
        n_tests++; if (ackq.size() !== ACK_N) begin n_fail++; $display("FAIL ch_ack_count: got %0d want %0d", ackq.size(), ACK_N); end
        if (ackq.size() > 0) begin
            n_tests++; if (ackq[0] !== 8'hA1) begin n_fail++; $display("FAIL ch_ack_byte: got %h want A1", ackq[0]); end
        end
        n_tests++; if (ack_data !== (ACK_N == 1 ? 8'hA1 : 8'h00)) begin n_fail++; $display("FAIL ch_ack_hold: got %h", ack_data); end
    endtask

    task automatic test_bright_sat();
        for (int i = 0; i < 7; i++) begin
            send_cmd(4'h4, 4'h1);
            n_tests++; if (brightness !== 4'(BD + 1 + i)) begin n_fail++; $display("FAIL bright_inc_%0d: got %0d want %0d", i, brightness, BD + 1 + i); end
            n_tests++; if (cfg_update !== 1'b1) begin n_fail++; $display("FAIL bright_inc_pulse_%0d: got %b want 1", i, cfg_update); end
            drain(G + 4);
        end
        ackq.delete(); ackt.delete();
        send_cmd(4'h4, 4'h1);
        n_tests++; if (brightness !== 4'd15) begin n_fail++; $display("FAIL bright_sat: got %0d want 15", brightness); end
        n_tests++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL bright_sat_pulse: got %b want 0", cfg_update); end
        drain(G + 6);
        n_tests++; if (ackq.size() !== ACK_N) begin n_fail++; $display("FAIL bright_sat_ack_count: got %0d want %0d", ackq.size(), ACK_N); end
        if (ackq.size() > 0) begin
            n_tests++; if (ackq[0] !== 8'hA4) begin n_fail++; $display("FAIL bright_sat_ack_byte: got %h want A4", ackq[0]); end
        end
        n_tests++; if (ack_overrun !== 1'b0) begin n_fail++; $display("FAIL bright_no_overrun: got %b want 0", ack_overrun); end
    endtask

    task automatic test_invalid();
        ackq.delete(); ackt.delete();
        send_cmd(4'h2, 4'h5);
        n_tests++; if (layout_mode !== 2'd0) begin n_fail++; $display("FAIL inv_layout: got %0d want 0", layout_mode); end
        n_tests++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL inv_layout_pulse: got %b want 0", cfg_update); end
        send_cmd(4'h7, 4'h3);
        n_tests++; if ({ch_sel, layout_mode, zoom_level, brightness} !== {2'd2, 2'd0, 3'd0, 4'd15}) begin
            n_fail++; $display("FAIL inv_op7_regs: got %0d/%0d/%0d/%0d want 2/0/0/15", ch_sel, layout_mode, zoom_level, brightness); end
        drain(2 * G + 10);
        n_tests++; if (ackq.size() !== 2 * ACK_N) begin n_fail++; $display("FAIL inv_ack_count: got %0d want %0d", ackq.size(), 2 * ACK_N); end
        if (ackq.size() == 2) begin
            n_tests++; if (ackq[0] !== 8'hE2) begin n_fail++; $display("FAIL inv_ack_e2: got %h want E2", ackq[0]); end
            n_tests++; if (ackq[1] !== 8'hE7) begin n_fail++; $display("FAIL inv_ack_e7: got %h want E7", ackq[1]); end
            n_tests++; if (ackt[1] - ackt[0] < int'(G)) begin n_fail++; $display("FAIL inv_ack_spacing: got %0d want >=%0d", ackt[1] - ackt[0], G); end
        end
        n_tests++; if (ack_overrun !== 1'b0) begin n_fail++; $display("FAIL inv_handoff_no_overrun: got %b want 0", ack_overrun); end
        send_cmd(4'h1, 4'h4); drain(G + 4);
        send_cmd(4'h3, 4'h8); drain(G + 4);
        send_cmd(4'h4, 4'h2); drain(G + 4);
        send_cmd(4'hF, 4'h5);
        n_tests++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL inv_misc_pulse: got %b want 0", cfg_update); end
        drain(G + 6);
        n_tests++; if ({ch_sel, layout_mode, zoom_level, brightness} !== {2'd2, 2'd0, 3'd0, 4'd15}) begin
            n_fail++; $display("FAIL inv_misc_regs: got %0d/%0d/%0d/%0d want 2/0/0/15", ch_sel, layout_mode, zoom_level, brightness); end
        n_tests++; if (ack_data !== (ACK_N == 1 ? 8'hEF : 8'h00)) begin n_fail++; $display("FAIL inv_misc_last_ack: got %h", ack_data); end
    endtask

    task automatic test_back_to_back();
        ackq.delete(); ackt.delete();
        send_cmd(4'h3, 4'h1);
        drain(2);
        n_tests++; if (ack_overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_pre_overrun: got %b want 0", ack_overrun); end
        send_cmd(4'h3, 4'h2);
        send_cmd(4'h3, 4'h5);
        send_cmd(4'h1, 4'h1);
        n_tests++; if (zoom_level !== 3'd5) begin n_fail++; $display("FAIL b2b_zoom: got %0d want 5", zoom_level); end
        n_tests++; if (ch_sel !== 2'd1) begin n_fail++; $display("FAIL b2b_ch_sel: got %0d want 1", ch_sel); end
        n_tests++; if (ack_overrun !== 1'(ACK_N)) begin n_fail++; $display("FAIL b2b_overrun: got %b want %0d", ack_overrun, ACK_N); end
        drain(2 * G + 10);
        n_tests++; if (ackq.size() !== 2 * ACK_N) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want %0d", ackq.size(), 2 * ACK_N); end
        if (ackq.size() == 2) begin
            n_tests++; if (ackq[0] !== 8'hA3) begin n_fail++; $display("FAIL b2b_first_ack: got %h want A3", ackq[0]); end
            n_tests++; if (ackq[1] !== 8'hA1) begin n_fail++; $display("FAIL b2b_last_ack: got %h want A1", ackq[1]); end
        end
    endtask

    task automatic test_restore();
        send_cmd(4'h2, 4'h3); drain(G + 4);
        send_cmd(4'h4, 4'h0);
        n_tests++; if (brightness !== 4'd14) begin n_fail++; $display("FAIL rest_bright_dec: got %0d want 14", brightness); end
        drain(G + 4);
        ackq.delete(); ackt.delete();
        send_cmd(4'hF, 4'hA);
        n_tests++; if ({ch_sel, layout_mode, zoom_level, brightness} !== {2'd0, 2'd0, 3'd0, 4'(BD)}) begin
            n_fail++; $display("FAIL rest_regs: got %0d/%0d/%0d/%0d want 0/0/0/%0d", ch_sel, layout_mode, zoom_level, brightness, BD); end
        n_tests++; if (cfg_update !== 1'b1) begin n_fail++; $display("FAIL rest_pulse: got %b want 1", cfg_update); end
        drain(G + 6);
        n_tests++; if (ackq.size() !== ACK_N) begin n_fail++; $display("FAIL rest_ack_count: got %0d want %0d", ackq.size(), ACK_N); end
        if (ackq.size() > 0) begin
            n_tests++; if (ackq[0] !== 8'hAF) begin n_fail++; $display("FAIL rest_ack_byte: got %h want AF", ackq[0]); end
        end
        n_tests++; if (ack_overrun !== 1'(ACK_N)) begin n_fail++; $display("FAIL rest_overrun_sticky: got %b want %0d", ack_overrun, ACK_N); end
        send_cmd(4'hF, 4'hA);
        n_tests++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL rest_repeat_pulse: got %b want 0", cfg_update); end
        drain(G + 6);
    endtask

    task automatic test_reset_mid_gap();
        send_cmd(4'h1, 4'h2);
        drain(2);
        send_cmd(4'h1, 4'h3);
        rst = 1'b0;
        drain(1);
        ackq.delete(); ackt.delete();
        drain(1);
        n_tests++; if ({ch_sel, layout_mode, zoom_level, brightness} !== {2'd0, 2'd0, 3'd0, 4'(BD)}) begin
            n_fail++; $display("FAIL rmg_regs: got %0d/%0d/%0d/%0d", ch_sel, layout_mode, zoom_level, brightness); end
        n_tests++; if ({ack_data, ack_flag, ack_overrun, cfg_update} !== 11'h0) begin
            n_fail++; $display("FAIL rmg_ack_outputs: got %h/%b/%b/%b want 00/0/0/0", ack_data, ack_flag, ack_overrun, cfg_update); end
        rst = 1'b1;
        drain(2 * G + 10);
        n_tests++; if (ackq.size() !== 0) begin n_fail++; $display("FAIL rmg_no_ack: got %0d strobes want 0", ackq.size()); end
        n_tests++; if ({ch_sel, ack_data, ack_overrun} !== 11'h0) begin
            n_fail++; $display("FAIL rmg_after_release: got ch %0d ack %h ovr %b", ch_sel, ack_data, ack_overrun); end
    endtask

    initial begin
        test_reset();
        test_ch_sel();
        test_bright_sat();
        test_invalid();
        test_back_to_back();
        test_restore();
        test_reset_mid_gap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
